// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate operand loader and equation datapath.
package mac_pkg;

  localparam int MAC_WORD_W = 32;
  localparam int MAC_OP_W   = 64;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_C, HOLD} loader_state_t;

  // Operand sequence within a frame: A, then B, then C, then the set is held.
  function automatic loader_state_t next_load(input loader_state_t s);
    case (s)
      LOAD_A:  next_load = LOAD_B;
      LOAD_B:  next_load = LOAD_C;
      default: next_load = HOLD;
    endcase
  endfunction

endpackage

// File: rtl/mac_operand_loader.sv
// Assembles A, B and C from a narrow word stream and holds the complete set
// stable for the combinational MAC until it is consumed.
module mac_operand_loader
  import mac_pkg::*;
#(
  parameter int WORD_W = MAC_WORD_W,
  parameter int OP_W   = MAC_OP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_W-1:0]     out_a,
  output logic [OP_W-1:0]     out_b,
  output logic [2*OP_W-1:0]   out_c,
  output logic                frame_err
);

  localparam int NA    = OP_W / WORD_W;
  localparam int NC    = 2 * NA;
  localparam int CNT_W = (NC > 1) ? $clog2(NC) : 1;

  loader_state_t       state;
  logic [CNT_W-1:0]    cnt;
  logic [OP_W-1:0]     opa_p0;
  logic [OP_W-1:0]     opb_p0;
  logic [2*OP_W-1:0]   opc_p0;
  logic                err_p0;

  logic                xfer;
  logic                final_c;
  logic                last_word;
  logic                bad_last;

  always_comb begin
    xfer      = in_valid && (state != HOLD);
    final_c   = (state == LOAD_C) && (cnt == CNT_W'(NC - 1));
    last_word = (state == LOAD_C) ? final_c : (cnt == CNT_W'(NA - 1));
    // in_last must coincide exactly with the final C word, nowhere else.
    bad_last  = (in_last != final_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD_A;
      cnt    <= '0;
      err_p0 <= 1'b0;
      opa_p0 <= '0;
      opb_p0 <= '0;
      opc_p0 <= '0;
    end else begin
      err_p0 <= 1'b0;
      if (state == HOLD) begin
        if (out_ready) state <= LOAD_A;
      end else if (xfer) begin
        if (bad_last) begin
          err_p0 <= 1'b1;
          state  <= LOAD_A;
          cnt    <= '0;
        end else if (last_word) begin
          state  <= next_load(state);
          cnt    <= '0;
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
        // Each operand register is written only from its own load state.
        for (int k = 0; k < NA; k++) begin
          if (cnt == CNT_W'(k)) begin
            if (state == LOAD_A) opa_p0[k*WORD_W +: WORD_W] <= in_data;
            if (state == LOAD_B) opb_p0[k*WORD_W +: WORD_W] <= in_data;
          end
        end
        for (int k = 0; k < NC; k++) begin
          if ((state == LOAD_C) && (cnt == CNT_W'(k)))
            opc_p0[k*WORD_W +: WORD_W] <= in_data;
        end
      end
    end
  end

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_a     = opa_p0;
  assign out_b     = opb_p0;
  assign out_c     = opc_p0;
  assign frame_err = err_p0;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Directed table-driven bench for mac_operand_loader at default widths.
module tb_mac_operand_loader;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_a;
  logic [63:0]   out_b;
  logic [127:0]  out_c;
  logic          frame_err;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0]  EXP_A = 64'h00000002_00000001;
  localparam logic [63:0]  EXP_B = 64'h00000004_00000003;
  localparam logic [127:0] EXP_C = 128'h00000008_00000007_00000006_00000005;

  mac_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // e_ops: 0 = operands not checked, 1 = all zero, 2 = the reference frame
  typedef struct {
    logic        rst;
    logic        iv;
    logic        il;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        e_fe;
    int          e_ops;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic iv, logic il, logic [31:0] d, logic ordy,
                              logic e_ir, logic e_ov, logic e_fe, int e_ops);
    vec_t v;
    v.rst = rst; v.iv = iv; v.il = il; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_fe = e_fe; v.e_ops = e_ops;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic iv, input logic il,
                     input logic [31:0] d, input logic ordy);
    reset = rst; in_valid = iv; in_last = il; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ops(input string name, input int sel);
    if (sel == 1) begin
      chk({name, "_a0"}, 128'(out_a), 128'd0);
      chk({name, "_b0"}, 128'(out_b), 128'd0);
      chk({name, "_c0"}, out_c, 128'd0);
    end else if (sel == 2) begin
      chk({name, "_a"}, 128'(out_a), 128'(EXP_A));
      chk({name, "_b"}, 128'(out_b), 128'(EXP_B));
      chk({name, "_c"}, out_c, EXP_C);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    // T1 reset for two cycles
    add(1, 0, 0, 32'h0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 32'h0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 32'h0, 0, 1, 0, 0, 1);
    // T2 clean frame, consumed immediately
    for (int w = 1; w <= 7; w++) add(0, 1, 0, 32'(w), 1, 1, 0, 0, 0);
    add(0, 1, 1, 32'd8, 1, 0, 1, 0, 2);
    add(0, 0, 0, 32'h0, 1, 1, 0, 0, 2);
    // T4 in_last on word 3, then a clean frame
    add(0, 1, 0, 32'h11, 1, 1, 0, 0, 0);
    add(0, 1, 0, 32'h22, 1, 1, 0, 0, 0);
    add(0, 1, 1, 32'h33, 1, 1, 0, 1, 0);
    add(0, 0, 0, 32'h0, 1, 1, 0, 0, 0);
    for (int w = 1; w <= 7; w++) add(0, 1, 0, 32'(w), 1, 1, 0, 0, 0);
    add(0, 1, 1, 32'd8, 1, 0, 1, 0, 2);
    add(0, 0, 0, 32'h0, 1, 1, 0, 0, 0);
    // T5 eight words without in_last
    for (int w = 1; w <= 7; w++) add(0, 1, 0, 32'(w + 16), 1, 1, 0, 0, 0);
    add(0, 1, 0, 32'd24, 1, 1, 0, 1, 0);
    add(0, 0, 0, 32'h0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 32'h0, 1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].iv, tbl[i].il, tbl[i].d, tbl[i].ordy);
      chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
      chk($sformatf("v%0d_frame_err", i), 128'(frame_err), 128'(tbl[i].e_fe));
      chk_ops($sformatf("v%0d", i), tbl[i].e_ops);
    end

    // T3 backpressure with junk offered while holding
    for (int w = 1; w <= 7; w++) cyc(0, 1, 0, 32'(w), 0);
    cyc(0, 1, 1, 32'd8, 0);
    chk("t3_valid_up", 128'(out_valid), 128'd1);
    for (int n = 0; n < 5; n++) begin
      cyc(0, 1, 1, 32'hdeadbeef, 0);
      chk($sformatf("t3_hold%0d_ov", n), 128'(out_valid), 128'd1);
      chk($sformatf("t3_hold%0d_ir", n), 128'(in_ready), 128'd0);
      chk($sformatf("t3_hold%0d_fe", n), 128'(frame_err), 128'd0);
      chk_ops($sformatf("t3_hold%0d", n), 2);
    end
    cyc(0, 0, 0, 32'h0, 1);
    chk("t3_release_ov", 128'(out_valid), 128'd0);
    chk("t3_release_ir", 128'(in_ready), 128'd1);

    // T6 reset mid-frame, then a frame with a gap after every word
    for (int w = 1; w <= 5; w++) cyc(0, 1, 0, 32'(w + 100), 1);
    cyc(1, 0, 0, 32'h0, 1);
    chk("t6_rst_ir", 128'(in_ready), 128'd1);
    chk("t6_rst_ov", 128'(out_valid), 128'd0);
    chk("t6_rst_fe", 128'(frame_err), 128'd0);
    chk_ops("t6_rst", 1);
    for (int w = 1; w <= 8; w++) begin
      cyc(0, 1, (w == 8), 32'(w), 1);
      if (w < 8) begin
        chk($sformatf("t6_w%0d_ov", w), 128'(out_valid), 128'd0);
        cyc(0, 0, 1, 32'hffffffff, 1);
        chk($sformatf("t6_gap%0d_ov", w), 128'(out_valid), 128'd0);
        chk($sformatf("t6_gap%0d_fe", w), 128'(frame_err), 128'd0);
      end else begin
        chk("t6_final_ov", 128'(out_valid), 128'd1);
        chk("t6_final_fe", 128'(frame_err), 128'd0);
        chk_ops("t6_final", 2);
      end
    end
    cyc(0, 0, 0, 32'h0, 1);
    chk("t6_done_ov", 128'(out_valid), 128'd0);
    chk("t6_done_ir", 128'(in_ready), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
